// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables, bubble/flush strobes,
// multi-cycle EX sequencing and saturating stall/redirect counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LATENCY     = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
  input  logic                      i_id_rs1_used,
  input  logic                      i_id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
  input  logic                      i_ex_mem_rd,
  input  logic                      i_ex_multicycle,
  input  logic                      i_ex_flush,
  input  logic                      i_mem_stall,
  output logic                      o_pc_en,
  output logic                      o_pc_sel_jump,
  output logic                      o_ifid_en,
  output logic                      o_ifid_flush,
  output logic                      o_idex_en,
  output logic                      o_idex_bubble,
  output logic                      o_exmem_en,
  output logic                      o_exmem_bubble,
  output logic                      o_memwb_en,
  output logic [1:0]                o_state,
  output logic [CNT_WIDTH-1:0]      o_stall_cycles,
  output logic [CNT_WIDTH-1:0]      o_flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1
  } state_t;

  state_t     state;
  logic [3:0] mc_cnt;
  logic       lu;
  logic       take_flush;

  assign lu = i_ex_mem_rd && (i_ex_rd != '0) &&
              ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
               (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

  assign take_flush = rst_n && !i_mem_stall && (state == RUN) && i_ex_flush;
  assign o_state    = state;

  always_comb begin
    o_pc_en        = 1'b0;
    o_pc_sel_jump  = 1'b0;
    o_ifid_en      = 1'b0;
    o_ifid_flush   = 1'b0;
    o_idex_en      = 1'b0;
    o_idex_bubble  = 1'b0;
    o_exmem_en     = 1'b0;
    o_exmem_bubble = 1'b0;
    o_memwb_en     = 1'b0;
    // Everything stays low in reset and while data memory freezes the pipe.
    if (rst_n && !i_mem_stall) begin
      o_pc_en    = 1'b1;
      o_ifid_en  = 1'b1;
      o_idex_en  = 1'b1;
      o_exmem_en = 1'b1;
      o_memwb_en = 1'b1;
      if (state == RUN) begin
        if (i_ex_flush) begin
          o_pc_sel_jump = 1'b1;
          o_ifid_flush  = 1'b1;
          o_idex_bubble = 1'b1;
        end else if (i_ex_multicycle) begin
          o_pc_en        = 1'b0;
          o_ifid_en      = 1'b0;
          o_idex_en      = 1'b0;
          o_exmem_bubble = 1'b1;
        end else if (lu) begin
          o_pc_en       = 1'b0;
          o_ifid_en     = 1'b0;
          o_idex_bubble = 1'b1;
        end
      end else if (mc_cnt != 4'd0) begin
        o_pc_en        = 1'b0;
        o_ifid_en      = 1'b0;
        o_idex_en      = 1'b0;
        o_exmem_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      mc_cnt         <= 4'd0;
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
    end else begin
      if (!o_pc_en && (o_stall_cycles != {CNT_WIDTH{1'b1}}))
        o_stall_cycles <= o_stall_cycles + 1'b1;
      if (take_flush && (o_flush_count != {CNT_WIDTH{1'b1}}))
        o_flush_count <= o_flush_count + 1'b1;
      if (!i_mem_stall) begin
        case (state)
          RUN: begin
            if (!i_ex_flush && i_ex_multicycle) begin
              state  <= MC_BUSY;
              mc_cnt <= 4'(MC_LATENCY - 2);
            end
          end
          MC_BUSY: begin
            // Counter==0 is the op's final EX cycle: it is captured this edge.
            if (mc_cnt != 4'd0) mc_cnt <= mc_cnt - 4'd1;
            else                state  <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed scoreboard bench for pipeline_hazard_ctrl against a cycle-level
// reference that tracks the multi-cycle op by its EX-cycle age.
module tb_pipeline_hazard_ctrl;
  localparam int RW  = 5;
  localparam int MCL = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_rs1_used = 0, id_rs2_used = 0, ex_mem_rd = 0, ex_multicycle = 0, ex_flush = 0, mem_stall = 0;
  logic pc_en, pc_sel_jump, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble, memwb_en;
  logic [1:0] state;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MC_LATENCY(MCL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_ex_rd(ex_rd), .i_ex_mem_rd(ex_mem_rd), .i_ex_multicycle(ex_multicycle),
    .i_ex_flush(ex_flush), .i_mem_stall(mem_stall),
    .o_pc_en(pc_en), .o_pc_sel_jump(pc_sel_jump), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
    .o_idex_en(idex_en), .o_idex_bubble(idex_bubble), .o_exmem_en(exmem_en),
    .o_exmem_bubble(exmem_bubble), .o_memwb_en(memwb_en), .o_state(state),
    .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]    ctl;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  // ctl order: pc_en, pc_sel_jump, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble, memwb_en
  localparam logic [8:0] C_ADV    = 9'b1_0_1_0_1_0_1_0_1;
  localparam logic [8:0] C_FLUSH  = 9'b1_1_1_1_1_1_1_0_1;
  localparam logic [8:0] C_MC     = 9'b0_0_0_0_0_0_1_1_1;
  localparam logic [8:0] C_LU     = 9'b0_0_0_0_1_1_1_0_1;
  localparam logic [8:0] C_FREEZE = 9'b0;

  exp_t exp_q[$];
  int   tag_q[$];
  int   n_cmp = 0, n_bad = 0, n_step = 0;
  bit   drive_done = 0;

  // Reference: age = which EX cycle the current multi-cycle op is in (0 = none).
  int age = 0, ref_sc = 0, ref_fc = 0;

  task automatic step(input logic rs, input int r1, input int r2, input logic u1, input logic u2,
                      input int rd, input logic mr, input logic mc, input logic fl, input logic ms);
    exp_t e;
    bit   hazard;
    @(posedge clk); #1;
    rst_n = rs; id_rs1 = RW'(r1); id_rs2 = RW'(r2); id_rs1_used = u1; id_rs2_used = u2;
    ex_rd = RW'(rd); ex_mem_rd = mr; ex_multicycle = mc; ex_flush = fl; mem_stall = ms;
    if (!rs) begin
      age = 0; ref_sc = 0; ref_fc = 0;
      e.ctl = C_FREEZE; e.st = 2'd0; e.sc = '0; e.fc = '0;
    end else begin
      hazard = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
      e.st = (age > 0) ? 2'd1 : 2'd0;
      e.sc = CW'(ref_sc); e.fc = CW'(ref_fc);
      if (ms)                 e.ctl = C_FREEZE;
      else if (age > 0) begin
        if (age < MCL) begin e.ctl = C_MC; age++; end
        else begin e.ctl = C_ADV; age = 0; end
      end
      else if (fl) begin e.ctl = C_FLUSH; ref_fc = (ref_fc < 15) ? ref_fc + 1 : 15; end
      else if (mc) begin e.ctl = C_MC; age = 2; end
      else if (hazard)        e.ctl = C_LU;
      else                    e.ctl = C_ADV;
      if (!e.ctl[8]) ref_sc = (ref_sc < 15) ? ref_sc + 1 : 15;
    end
    exp_q.push_back(e);
    tag_q.push_back(n_step);
    n_step++;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_cycle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle; compare each against the oldest pending expectation.
  initial begin : monitor
    exp_t e, a;
    int   t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a.ctl = {pc_en, pc_sel_jump, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble, memwb_en};
        a.st = state; a.sc = stall_cycles; a.fc = flush_count;
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL step%0d: got ctl=%b st=%0d stall=%0d flush=%0d, want ctl=%b st=%0d stall=%0d flush=%0d",
                   t, a.ctl, a.st, a.sc, a.fc, e.ctl, e.st, e.sc, e.fc);
        end
      end
    end
  end

  initial begin : driver
    int r;
    // Load-use on rs1, then the same with x0 as destination (no hazard).
    rst_cycle();
    step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0); idle(); idle();
    rst_cycle();
    step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0); step(1, 3, 7, 0, 1, 7, 1, 0, 0, 0); idle();
    // Redirect beats a simultaneous load-use.
    rst_cycle();
    step(1, 5, 0, 1, 0, 5, 1, 0, 1, 0); idle();
    // Multi-cycle op held for MC_LATENCY cycles.
    rst_cycle();
    for (int i = 0; i < MCL; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(); idle();
    // Multi-cycle op with a two-cycle memory freeze on its second stall cycle.
    rst_cycle();
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(); idle();
    // Freeze masks a pending redirect until release.
    rst_cycle();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); idle(); idle();
    // Stall counter saturation.
    rst_cycle();
    for (int i = 0; i < 17; i++) step(1, 9, 0, 1, 0, 9, 1, 0, 0, 0);
    idle(); idle();
    // Flush counter saturation.
    rst_cycle();
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    // Async reset while MC_BUSY.
    rst_cycle();
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rst_cycle(); rst_cycle(); idle(); idle();
    // Random traffic; small register range so hazards actually occur.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      step(r >= 2, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 9) < 4,
           $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
    end
    idle();
    drive_done = 1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!drive_done && budget < 5000) begin @(posedge clk); budget++; end
    @(negedge clk); @(negedge clk); #1;
    if (!drive_done || exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: done=%0d pending=%0d, want done=1 pending=0", drive_done, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
